// File: rtl/unidad_riesgos_pkg.sv
// unidad_riesgos_pkg: shared encodings, slot record and forwarding helper for the hazard unit
package unidad_riesgos_pkg;
    localparam int RB = 5;
    localparam logic [1:0] ADEL_REG = 2'b00;
    localparam logic [1:0] ADEL_WB  = 2'b01;
    localparam logic [1:0] ADEL_MEM = 2'b10;
    typedef enum logic [1:0] {NORMAL, ESPERA_MEM, VACIADO, STALL_CARGA} modo_t;
    typedef struct packed {
        logic          valido;
        logic [RB-1:0] rs;
        logic [RB-1:0] rt;
        logic          usa_rs;
        logic          usa_rt;
        logic [RB-1:0] dest;
        logic          escribe;
        logic          lee_mem;
    } slot_t;
    function automatic logic escribe_a(slot_t s, logic [RB-1:0] r);
        return s.valido && s.escribe && s.dest != '0 && s.dest == r;
    endfunction
endpackage

// File: rtl/unidad_riesgos_comparador_adelanto.sv
// comparador_adelanto: forwarding select for one EX operand, MEM has priority over WB
module comparador_adelanto
    import unidad_riesgos_pkg::*;
(
    input  logic          valido,
    input  logic          usa,
    input  logic [RB-1:0] fuente,
    input  slot_t         mem,
    input  slot_t         wb,
    output logic [1:0]    sel
);
    // r0 never matches because escribe_a rejects dest 0
    always_comb sel = !(valido && usa) ? ADEL_REG :
                      escribe_a(mem, fuente) ? ADEL_MEM :
                      escribe_a(wb, fuente)  ? ADEL_WB  : ADEL_REG;
endmodule

// File: rtl/unidad_riesgos.sv
// unidad_riesgos: load-use stall, branch flush, memory freeze and forwarding control
module unidad_riesgos
    import unidad_riesgos_pkg::*;
#(
    parameter int REG_BITS = RB,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_BITS-1:0] rsID,
    input  logic [REG_BITS-1:0] rtID,
    input  logic                usaRsID,
    input  logic                usaRtID,
    input  logic [REG_BITS-1:0] regDestID,
    input  logic                escribeRegID,
    input  logic                leeMemID,
    input  logic                saltoTomadoEX,
    input  logic                memOcupada,
    output logic                congelarPC,
    output logic                congelarIFID,
    output logic                limpiarIFID,
    output logic                burbujaIDEX,
    output logic                congelarTodo,
    output logic [1:0]          adelantarA,
    output logic [1:0]          adelantarB,
    output logic [CNT_BITS-1:0] ciclosStall
);
    slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_s;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [1:0] sel_a, sel_b;
    logic carga, pierde;
    modo_t modo;

    comparador_adelanto u_adel_a (
        .valido(ex_q.valido), .usa(ex_q.usa_rs), .fuente(ex_q.rs),
        .mem(mem_q), .wb(wb_q), .sel(sel_a)
    );
    comparador_adelanto u_adel_b (
        .valido(ex_q.valido), .usa(ex_q.usa_rt), .fuente(ex_q.rt),
        .mem(mem_q), .wb(wb_q), .sel(sel_b)
    );

    // mode priority, next slot contents and saturating lost-cycle counter
    always_comb begin
        id_s  = '{1'b1, rsID, rtID, usaRsID, usaRtID, regDestID, escribeRegID, leeMemID};
        carga = ex_q.valido && ex_q.lee_mem && ex_q.dest != '0 &&
                ((usaRsID && ex_q.dest == rsID) || (usaRtID && ex_q.dest == rtID));
        modo  = memOcupada ? ESPERA_MEM : saltoTomadoEX ? VACIADO : carga ? STALL_CARGA : NORMAL;
        pierde = modo == VACIADO || modo == STALL_CARGA;
        ex_d  = modo == NORMAL ? id_s : modo == ESPERA_MEM ? ex_q : '0;
        mem_d = modo == ESPERA_MEM ? mem_q : ex_q;
        wb_d  = modo == ESPERA_MEM ? wb_q : mem_q;
        cnt_d = pierde && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
    end

    // outputs are forced low while reset is held
    always_comb begin
        congelarPC   = !reset && (modo == ESPERA_MEM || modo == STALL_CARGA);
        congelarIFID = congelarPC;
        limpiarIFID  = !reset && modo == VACIADO;
        burbujaIDEX  = !reset && pierde;
        congelarTodo = !reset && modo == ESPERA_MEM;
        adelantarA   = reset ? ADEL_REG : sel_a;
        adelantarB   = reset ? ADEL_REG : sel_b;
        ciclosStall  = reset ? '0 : cnt_q;
    end

    // shadow slots and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_unidad_riesgos.sv
// tb_unidad_riesgos: scoreboard bench with a behavioural pipeline model
module tb_unidad_riesgos;
    localparam int CB = 4;
    localparam int W = 9 + CB;

    logic clk = 0;
    logic reset = 1;
    logic [4:0] rsID = 0, rtID = 0, regDestID = 0;
    logic usaRsID = 0, usaRtID = 0, escribeRegID = 0, leeMemID = 0, saltoTomadoEX = 0, memOcupada = 0;
    logic congelarPC, congelarIFID, limpiarIFID, burbujaIDEX, congelarTodo;
    logic [1:0] adelantarA, adelantarB;
    logic [CB-1:0] ciclosStall;

    unidad_riesgos #(.REG_BITS(5), .CNT_BITS(CB)) dut (
        .clk(clk), .reset(reset), .rsID(rsID), .rtID(rtID), .usaRsID(usaRsID), .usaRtID(usaRtID),
        .regDestID(regDestID), .escribeRegID(escribeRegID), .leeMemID(leeMemID),
        .saltoTomadoEX(saltoTomadoEX), .memOcupada(memOcupada),
        .congelarPC(congelarPC), .congelarIFID(congelarIFID), .limpiarIFID(limpiarIFID),
        .burbujaIDEX(burbujaIDEX), .congelarTodo(congelarTodo),
        .adelantarA(adelantarA), .adelantarB(adelantarB), .ciclosStall(ciclosStall)
    );

    always #5 clk = ~clk;

    wire [W-1:0] got = {congelarPC, congelarIFID, limpiarIFID, burbujaIDEX, congelarTodo,
                        adelantarA, adelantarB, ciclosStall};

    typedef struct {bit v; int rs, rt; bit ur, ut; int d; bit w, l;} ins_t;
    ins_t pipe[3];
    int cnt = 0;
    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    logic [W-1:0] sb[$];

    function automatic logic [1:0] fwd(int src, bit u);
        if (!pipe[0].v || !u || src == 0) return 2'b00;
        for (int k = 1; k <= 2; k++)
            if (pipe[k].v && pipe[k].w && pipe[k].d == src) return k == 1 ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    task automatic model();
        ins_t id, nada;
        bit hz, fr, fl, st;
        logic [W-1:0] e;
        nada = '{0, 0, 0, 0, 0, 0, 0, 0};
        if (reset) begin
            e = '0;
            for (int k = 0; k < 3; k++) pipe[k] = nada;
            cnt = 0;
        end else begin
            id = '{1, int'(rsID), int'(rtID), usaRsID, usaRtID, int'(regDestID), escribeRegID, leeMemID};
            hz = pipe[0].v && pipe[0].l && pipe[0].d != 0 &&
                 ((usaRsID && pipe[0].d == rsID) || (usaRtID && pipe[0].d == rtID));
            fr = memOcupada;
            fl = !fr && saltoTomadoEX;
            st = !fr && !fl && hz;
            e = {fr || st, fr || st, fl, fl || st, fr,
                 fwd(pipe[0].rs, pipe[0].ur), fwd(pipe[0].rt, pipe[0].ut), CB'(cnt)};
            if (!fr) begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = (fl || st) ? nada : id;
                if ((fl || st) && cnt < (1 << CB) - 1) cnt++;
            end
        end
        sb.push_back(e);
    endtask

    task automatic cyc(input int rs, input int rt, input bit ur, input bit ut, input int d,
                       input bit w, input bit l, input bit br, input bit mo, input bit rst);
        @(posedge clk);
        #1;
        rsID = 5'(rs); rtID = 5'(rt); usaRsID = ur; usaRtID = ut; regDestID = 5'(d);
        escribeRegID = w; leeMemID = l; saltoTomadoEX = br; memOcupada = mo; reset = rst;
        model();
    endtask

    task automatic nop(); cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic rst(); cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] r);
        checks++;
        if (a !== r) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, a, r);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            logic [W-1:0] e;
            e = sb.pop_front();
            checks++;
            ncyc++;
            if (got !== e) begin
                errors++;
                $display("FAIL sb_cycle%0d got %0h want %0h", ncyc, got, e);
            end
        end
    end

    initial begin
        rst(); rst();
        @(negedge clk);
        chk("reset_outs", 32'(got), 0);

        rst();
        cyc(0, 0, 0, 0, 8, 1, 1, 0, 0, 0);
        cyc(8, 0, 1, 0, 9, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("lu_stall", {congelarPC, congelarIFID, burbujaIDEX, limpiarIFID}, 4'b1110);
        cyc(8, 0, 1, 0, 9, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("lu_once", congelarPC, 0);
        nop();
        @(negedge clk);
        chk("lu_fwd_wb", adelantarA, 2'b01);
        chk("lu_cnt", ciclosStall, 1);

        rst();
        cyc(1, 2, 1, 1, 3, 1, 0, 0, 0, 0);
        cyc(3, 3, 1, 1, 4, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("alu_nostall", congelarPC, 0);
        nop();
        @(negedge clk);
        chk("alu_fwd", {adelantarA, adelantarB}, 4'b1010);

        rst();
        cyc(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 6, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("r0_nostall", congelarPC, 0);
        nop();
        @(negedge clk);
        chk("r0_fwd", {adelantarA, adelantarB}, 0);

        rst();
        cyc(0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(5, 0, 1, 0, 7, 1, 0, 1, 1, 0);
            @(negedge clk);
            chk("mw_freeze", {congelarPC, congelarIFID, limpiarIFID, burbujaIDEX, congelarTodo}, 5'b11001);
        end
        cyc(5, 0, 1, 0, 7, 1, 0, 1, 0, 0);
        @(negedge clk);
        chk("mw_flush", {congelarPC, limpiarIFID, burbujaIDEX, congelarTodo}, 4'b0110);
        nop();
        @(negedge clk);
        chk("mw_cnt", ciclosStall, 1);

        rst();
        cyc(0, 0, 0, 0, 8, 1, 1, 0, 0, 0);
        cyc(0, 8, 0, 1, 2, 1, 0, 1, 0, 0);
        @(negedge clk);
        chk("fb_outs", {congelarPC, limpiarIFID, burbujaIDEX}, 3'b011);
        nop();
        @(negedge clk);
        chk("fb_cnt", ciclosStall, 1);

        rst();
        cyc(0, 0, 0, 0, 8, 1, 1, 0, 0, 0);
        cyc(8, 0, 1, 0, 9, 1, 0, 0, 0, 0);
        cyc(8, 0, 1, 0, 9, 1, 0, 1, 1, 1);
        @(negedge clk);
        chk("rst_during", 32'(got), 0);
        nop();
        @(negedge clk);
        chk("rst_after", 32'(got), 0);

        rst();
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 40) == 0);
        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
